stall_buffer_reader: RTL and testbench

Read-side drain for the two-slot pipeline stall buffer. It pops 32-bit words from the buffer head using the buffer's empty flag and deq strobe. It presents the words to the downstream stage through a valid/ready handshake, using a registered output with one skid entry. It also counts downstream stall cycles and delivered words for performance monitoring.

---
 rtl/stall_buffer_reader_if.sv | 34 +++
 rtl/stall_buffer_reader.sv | 140 ++++++++++++++
 tb/tb_stall_buffer_reader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/stall_buffer_reader_if.sv
// Bundles the reader's two handshakes: the pop side facing the stall buffer
// (empty/deq/head word) and the valid/ready side facing the downstream stage.
// The reader itself uses the master view; the environment uses the slave view.
interface stall_buffer_reader_if #(
    parameter int DW = 32
);
    // Buffer head side
    logic [DW-1:0] buf_data;
    logic          buf_empty;
    logic          buf_deq;

    // Downstream side
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        input  buf_data,
        input  buf_empty,
        output buf_deq,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output buf_data,
        output buf_empty,
        input  buf_deq,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/stall_buffer_reader.sv
// Read-side drain for the two-slot pipeline stall buffer.
// Pops words from the buffer head and presents them downstream through a
// registered main stage backed by one skid entry, so a word can be accepted
// in the same cycle that downstream stalls. Also keeps a saturating count
// of stalled cycles and a wrapping count of delivered words.
module stall_buffer_reader #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    stall_buffer_reader_if.master        bus,
    output logic [CW-1:0]                stall_cycles_o,
    output logic [CW-1:0]                words_out_o,
    output logic [1:0]                   occupancy_o
);

    // Occupancy states: EMPTY holds nothing, ONE holds a word in main,
    // TWO additionally holds a word in skid (skid never valid without main).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] main_q,  main_d;
    logic [DW-1:0] skid_q,  skid_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [CW-1:0] words_q, words_d;

    logic main_v;
    logic skid_v;
    logic take;
    logic fire;
    logic stalled;

    assign main_v = (state_q != ST_EMPTY);
    assign skid_v = (state_q == ST_TWO);

    // Pop only when there is somewhere to put the word. Reset is included so
    // the buffer is never popped while the reader is being cleared.
    assign take    = !reset && !bus.buf_empty && !flush_i && !skid_v;
    assign fire    = main_v && bus.out_ready;
    assign stalled = main_v && !bus.out_ready;

    assign bus.buf_deq   = take;
    assign bus.out_data  = main_q;
    assign bus.out_valid = main_v;

    assign occupancy_o    = {1'b0, main_v} + {1'b0, skid_v};
    assign stall_cycles_o = stall_q;
    assign words_out_o    = words_q;

    // State and data registers; async reset drops everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and data-path selection; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (take) begin
                        main_d  = bus.buf_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (take && fire) begin
                        // Word leaves and the next one replaces it: full rate.
                        main_d = bus.buf_data;
                    end else if (take) begin
                        // Downstream stalled; park the new word behind main.
                        skid_d  = bus.buf_data;
                        state_d = ST_TWO;
                    end else if (fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            words_q <= '0;
        end else begin
            stall_q <= stall_d;
            words_q <= words_d;
        end
    end

    // Stall count saturates at all-ones; delivered-word count wraps.
    // A handshake coinciding with flush is discarded along with the counts.
    always_comb begin
        stall_d = stall_q;
        words_d = words_q;
        if (flush_i) begin
            stall_d = '0;
            words_d = '0;
        end else begin
            if (stalled && (stall_q != {CW{1'b1}})) begin
                stall_d = stall_q + 1'b1;
            end
            if (fire) begin
                words_d = words_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stall_buffer_reader.sv
// Directed and randomized bench for stall_buffer_reader. The source buffer
// and the reader contents are modelled as plain queues; expected outputs
// follow from queue sizes and the flow rules, counters from simple arithmetic.
module tb_stall_buffer_reader;
    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] words_out;
    logic [1:0]    occupancy;

    stall_buffer_reader_if #(.DW(DW)) bus ();

    stall_buffer_reader #(.DW(DW), .CW(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush),
        .bus            (bus),
        .stall_cycles_o (stall_cycles),
        .words_out_o    (words_out),
        .occupancy_o    (occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] src[$];   // words waiting in the upstream buffer
    logic [DW-1:0] held[$];  // words held by the reader, oldest first
    int            m_stall;
    int            m_words;
    bit            m_zero;   // data registers known to be cleared

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        held.delete();
        m_stall = 0;
        m_words = 0;
        m_zero  = 1'b1;
    endtask

    // One clock cycle: drive, check pre-edge outputs, advance the model.
    task automatic cycle(input bit rdy, input bit fl, input bit avail);
        bit exp_valid;
        bit exp_deq;
        bit fire;
        bus.out_ready = rdy;
        flush         = fl;
        if (avail && src.size() > 0) begin
            bus.buf_empty = 1'b0;
            bus.buf_data  = src[0];
        end else begin
            bus.buf_empty = 1'b1;
            bus.buf_data  = $urandom;
        end
        #2;
        exp_valid = (held.size() > 0);
        exp_deq   = !bus.buf_empty && !fl && (held.size() < 2);
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
        chk("buf_deq", {31'b0, bus.buf_deq}, {31'b0, exp_deq});
        chk("occupancy", {30'b0, occupancy}, held.size());
        chk("stall_cycles", {28'b0, stall_cycles}, m_stall);
        chk("words_out", {28'b0, words_out}, m_words);
        if (exp_valid)
            chk("out_data", bus.out_data, held[0]);
        else if (m_zero)
            chk("out_data_clr", bus.out_data, '0);
        fire = exp_valid && rdy;
        @(posedge clk);
        #1;
        if (fl) begin
            model_clear();
        end else begin
            if (exp_valid && !rdy && m_stall < SAT) m_stall++;
            if (fire) begin
                void'(held.pop_front());
                m_words = (m_words + 1) % (SAT + 1);
            end
            if (exp_deq) begin
                held.push_back(src.pop_front());
                m_zero = 1'b0;
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.buf_empty = 1'b1;
        bus.buf_data  = '0;
        bus.out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        $display("step: reset released");

        // Idle after reset: nothing to pop, nothing presented.
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        $display("step: idle total=%0d", total);

        // Streaming at full rate.
        src.push_back(32'hA1);
        src.push_back(32'hB2);
        repeat (4) cycle(1'b1, 1'b0, 1'b1);
        chk("stream_words", {28'b0, words_out}, 32'd2);
        chk("stream_stall", {28'b0, stall_cycles}, 32'd0);
        $display("step: streaming total=%0d", total);

        // Backpressure: two words taken, third left in the buffer.
        src.push_back(32'h11);
        src.push_back(32'h22);
        src.push_back(32'h33);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        chk("bp_occupancy", {30'b0, occupancy}, 32'd2);
        chk("bp_stall", {28'b0, stall_cycles}, 32'd3);
        chk("bp_head", bus.out_data, 32'h11);
        repeat (5) cycle(1'b1, 1'b0, 1'b1);
        $display("step: backpressure total=%0d", total);

        // Flush while full with downstream ready and a word still upstream.
        src.push_back(32'h44);
        src.push_back(32'h55);
        src.push_back(32'h66);
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        chk("pre_flush_occ", {30'b0, occupancy}, 32'd2);
        cycle(1'b1, 1'b1, 1'b1);
        chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_occ", {30'b0, occupancy}, 32'd0);
        chk("flush_words", {28'b0, words_out}, 32'd0);
        chk("flush_stall", {28'b0, stall_cycles}, 32'd0);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        $display("step: flush total=%0d", total);

        // Stall counter saturation.
        src.push_back(32'h77);
        repeat (21) cycle(1'b0, 1'b0, 1'b1);
        chk("stall_sat", {28'b0, stall_cycles}, SAT);
        cycle(1'b1, 1'b1, 1'b0);
        // Word counter wrap: 17 handshakes.
        for (int i = 0; i < 17; i++) src.push_back($urandom);
        repeat (19) cycle(1'b1, 1'b0, 1'b1);
        chk("words_wrap", {28'b0, words_out}, 32'd1);
        $display("step: counters total=%0d", total);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) src.push_back($urandom);
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 4) != 0);
        end
        $display("step: random total=%0d", total);

        // Asynchronous reset in the middle of a cycle while full.
        for (int i = 0; i < 3; i++) src.push_back(32'hC0 + i);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        chk("pre_reset_occ", {30'b0, occupancy}, 32'd2);
        chk("pre_reset_deq", {31'b0, bus.buf_deq}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("arst_occ", {30'b0, occupancy}, 32'd0);
        chk("arst_deq", {31'b0, bus.buf_deq}, 32'd0);
        chk("arst_data", bus.out_data, 32'd0);
        @(posedge clk);
        #1;
        chk("arst_deq_edge", {31'b0, bus.buf_deq}, 32'd0);
        reset = 1'b0;
        model_clear();
        repeat (4) cycle(1'b1, 1'b0, 1'b1);
        $display("step: async reset total=%0d", total);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
